debounce_pulse: RTL

DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

---
 rtl/debounce_pulse.sv | 124 ++++++++++++
 1 files changed

// File: rtl/debounce_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pulse
//  Description : Debounces a level that has already been synchronized to clk.
//                A new level is accepted once it has been seen on DB_CNT+1
//                consecutive rising edges. Every accepted transition gives a
//                one-cycle rise or fall strobe on the same edge that
//                level_out changes.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RST_VAL : debounced level held during reset (same as the synchronizer's
//              reset value)
//    CNT_W   : stability counter width
//    DB_CNT  : consecutive stable cycles required, 1 .. 2^CNT_W-1
//  Ports
//    clk        in   single clock, rising edge
//    rst        in   synchronous active-high reset
//    sync_in    in   synchronized raw level (not re-synchronized here)
//    level_out  out  debounced level, registered
//    rise_pulse out  one-cycle strobe on each debounced 0->1, registered
//    fall_pulse out  one-cycle strobe on each debounced 1->0, registered
// ============================================================================
module debounce_pulse #(
    parameter logic RST_VAL = 1'b0,
    parameter int   CNT_W   = 16,
    parameter int   DB_CNT  = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    // The counter is only ever compared with this terminal value. DB_CNT is
    // at most 2^CNT_W-1, so the counter tops out at 2^CNT_W-2 and never wraps.
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DB_CNT - 1);

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_CHK_HI = 2'd1,
        S_HIGH   = 2'd2,
        S_CHK_LO = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Any partial count is discarded; reset never produces a strobe.
            state_q <= RST_VAL ? S_HIGH : S_LOW;
            cnt_q   <= '0;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // Strobes live for exactly one cycle.
            rise_q <= 1'b0;
            fall_q <= 1'b0;

            case (state_q)
                S_LOW: begin
                    if (sync_in) begin
                        state_q <= S_CHK_HI;
                        cnt_q   <= '0;
                    end
                end

                S_CHK_HI: begin
                    if (!sync_in) begin
                        // Old level seen again: abort, level unchanged.
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == C_CNT_MAX) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_HIGH: begin
                    if (!sync_in) begin
                        state_q <= S_CHK_LO;
                        cnt_q   <= '0;
                    end
                end

                S_CHK_LO: begin
                    if (sync_in) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == C_CNT_MAX) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule
`default_nettype wire
